// File: rtl/freq_meter_pkg.sv
// Shared definitions for the gated frequency meter.
// Holds the FSM state encoding used by freq_meter.
package freq_meter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_GATE = 2'd1;
    localparam state_t ST_HOLD = 2'd2;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Ports: clk, rst (async, active high), d (async input), rise_p (1-cycle pulse).
// rise_p lags a rising edge on d by 3 clk cycles.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise_p
);

    logic meta_q;
    logic sync_q;
    logic sync_qq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            sync_qq <= 1'b0;
            rise_p  <= 1'b0;
        end else begin
            meta_q  <= d;
            sync_q  <= meta_q;
            sync_qq <= sync_q;
            rise_p  <= sync_q & ~sync_qq;
        end
    end

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of sig_in over GATE_CYCLES clocks.
// Ports: clk, rst, sig_in, start -> busy, freq_cnt, overflow, valid; ready handshake.
// Result is held in HOLD until valid & ready; start in that cycle re-arms directly.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int GATE_CYCLES = 100_000_000,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] freq_cnt,
    output logic             overflow,
    output logic             valid,
    input  logic             ready
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LOAD = GW'(GATE_CYCLES - 1);

    if (CLK_HZ < 1 || GATE_CYCLES < 2) begin : g_param_check
        $error("freq_meter: CLK_HZ must be >= 1 and GATE_CYCLES >= 2");
    end

    logic             edge_p;
    state_t           state;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             ovf;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;

    edge_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (sig_in),
        .rise_p (edge_p)
    );

    // Saturating count including the current cycle's edge, so the terminal
    // gate cycle can load the result with its own edge already counted.
    always_comb begin
        cnt_nxt = edge_cnt;
        ovf_nxt = ovf;
        if (edge_p) begin
            if (&edge_cnt) ovf_nxt = 1'b1;
            else           cnt_nxt = edge_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
            freq_cnt <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_GATE;
                        busy     <= 1'b1;
                        gate_cnt <= GATE_LOAD;
                        edge_cnt <= '0;
                        ovf      <= 1'b0;
                    end
                end
                ST_GATE: begin
                    edge_cnt <= cnt_nxt;
                    ovf      <= ovf_nxt;
                    gate_cnt <= gate_cnt - 1'b1;
                    if (gate_cnt == '0) begin
                        state    <= ST_HOLD;
                        busy     <= 1'b0;
                        freq_cnt <= cnt_nxt;
                        overflow <= ovf_nxt;
                        valid    <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (ready) begin
                        valid <= 1'b0;
                        if (start) begin
                            state    <= ST_GATE;
                            busy     <= 1'b1;
                            gate_cnt <= GATE_LOAD;
                            edge_cnt <= '0;
                            ovf      <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
